// File: rtl/sensor_frame_pkg.sv
// Shared types and constants for the sensor frame generator.
package sensor_frame_pkg;

  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hF5A5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GAP     = 2'd1,
    ST_HEADER  = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  // Number of input patterns that make up one 64-bit output word.
  function automatic int unsigned pattern_ratio(input int unsigned pw);
    return 64 / pw;
  endfunction

endpackage

// File: rtl/sensor_frame_packer.sv
// PATTERN_WIDTH -> 64-bit little-endian upsizer with a registered output word.
module sensor_frame_packer
  import sensor_frame_pkg::*;
#(
  parameter int PATTERN_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [PATTERN_WIDTH-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [63:0]              out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready
);

  localparam int unsigned RATIO = pattern_ratio(PATTERN_WIDTH);

  logic [63:0] acc_p0;
  logic [2:0]  fill_p0;
  logic        last_p0;
  logic [63:0] word_p1;
  logic        vld_p1;
  logic        last_p1;

  logic        in_hs;
  logic        word_done;
  logic [63:0] word_next;

  // A slot is free unless this pattern completes a word that cannot leave yet.
  assign in_ready  = (32'(fill_p0) < RATIO - 1) || !vld_p1 || out_ready;
  assign in_hs     = in_valid && in_ready;
  assign word_done = in_hs && (32'(fill_p0) == RATIO - 1);

  always_comb begin
    word_next = acc_p0;
    word_next[fill_p0*PATTERN_WIDTH +: PATTERN_WIDTH] = in_data;
  end

  // Stage p0: accumulation; stage p1: output word register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fill_p0 <= '0;
      last_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (word_done) begin
      fill_p0 <= '0;
      last_p0 <= 1'b0;
      vld_p1  <= 1'b1;
      last_p1 <= last_p0 | in_last;
    end else begin
      if (in_hs) begin
        fill_p0 <= fill_p0 + 3'd1;
        last_p0 <= last_p0 | in_last;
      end
      if (vld_p1 && out_ready) vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs)     acc_p0  <= word_next;
    if (word_done) word_p1 <= word_next;
  end

  assign out_data  = word_p1;
  assign out_valid = vld_p1;
  assign out_last  = last_p1;

endmodule

// File: rtl/sensor_frame_gen.sv
// Frames packed sensor patterns as header + fixed payload, paced by a gap.
module sensor_frame_gen
  import sensor_frame_pkg::*;
#(
  parameter int          PATTERN_WIDTH = 32,
  parameter logic [15:0] HDR_MAGIC     = HDR_MAGIC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_ENABLE,
  input  logic [31:0]              i_CELLS_PER_FRAME,
  input  logic [15:0]              i_FRAME_GAP,
  input  logic                     i_CLR_STATS_wstrobe,
  output logic [31:0]              o_FRAME_COUNT,
  output logic [31:0]              o_UNDERFLOW,
  output logic                     o_CFG_ERR,
  output logic                     o_BUSY,
  input  logic [PATTERN_WIDTH-1:0] AXIS_IN_TDATA,
  input  logic                     AXIS_IN_TVALID,
  output logic                     AXIS_IN_TREADY,
  output logic [63:0]              AXIS_OUT_TDATA,
  output logic                     AXIS_OUT_TVALID,
  output logic                     AXIS_OUT_TLAST,
  input  logic                     AXIS_OUT_TREADY
);

  localparam int unsigned RATIO = pattern_ratio(PATTERN_WIDTH);

  state_t      state, state_nxt;
  logic [31:0] cells_sh, frame_num, in_cnt, frame_count, underflow;
  logic [15:0] gap_sh, gap_cnt;
  logic        cfg_err;

  logic        cfg_ok, seg_end, start_try, start_ok, start_bad;
  logic        accept_en, hdr_hs, last_hs, in_hs, uf_evt;
  logic        pk_in_ready, pk_vld, pk_last;
  logic [63:0] pk_data;

  assign cfg_ok    = (i_CELLS_PER_FRAME != 32'd0) && (i_CELLS_PER_FRAME % RATIO == 32'd0);
  assign accept_en = (state == ST_PAYLOAD) && (in_cnt != 32'd0);
  assign in_hs     = AXIS_IN_TVALID && AXIS_IN_TREADY;
  assign hdr_hs    = (state == ST_HEADER) && AXIS_OUT_TREADY;
  assign last_hs   = (state == ST_PAYLOAD) && pk_vld && pk_last && AXIS_OUT_TREADY;
  assign uf_evt    = (state == ST_PAYLOAD) && !pk_vld && !AXIS_IN_TVALID;

  // A zero gap makes the TLAST handshake itself the end of the gap.
  assign seg_end   = ((state == ST_GAP) && (gap_cnt == 16'd1)) || (last_hs && (gap_sh == 16'd0));
  assign start_try = i_ENABLE && ((state == ST_IDLE) || seg_end);
  assign start_ok  = start_try && cfg_ok;
  assign start_bad = start_try && !cfg_ok;

  sensor_frame_packer #(
    .PATTERN_WIDTH(PATTERN_WIDTH)
  ) u_packer (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (AXIS_IN_TDATA),
    .in_valid (AXIS_IN_TVALID && accept_en),
    .in_last  (in_cnt == 32'd1),
    .in_ready (pk_in_ready),
    .out_data (pk_data),
    .out_valid(pk_vld),
    .out_last (pk_last),
    .out_ready(AXIS_OUT_TREADY && (state == ST_PAYLOAD))
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    AXIS_IN_TREADY  = 1'b0;
    AXIS_OUT_TVALID = 1'b0;
    AXIS_OUT_TLAST  = 1'b0;
    AXIS_OUT_TDATA  = '0;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_HEADER;
      end
      ST_GAP: begin
        if (seg_end) state_nxt = start_ok ? ST_HEADER : ST_IDLE;
      end
      ST_HEADER: begin
        AXIS_OUT_TVALID = 1'b1;
        AXIS_OUT_TDATA  = {HDR_MAGIC, 16'(cells_sh / RATIO), frame_num};
        if (hdr_hs) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        AXIS_IN_TREADY  = accept_en && pk_in_ready;
        AXIS_OUT_TVALID = pk_vld;
        AXIS_OUT_TLAST  = pk_vld && pk_last;
        AXIS_OUT_TDATA  = pk_vld ? pk_data : 64'd0;
        if (last_hs) begin
          if (gap_sh != 16'd0) state_nxt = ST_GAP;
          else                 state_nxt = start_ok ? ST_HEADER : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cells_sh    <= '0;
      gap_sh      <= '0;
      gap_cnt     <= '0;
      frame_num   <= '0;
      in_cnt      <= '0;
      frame_count <= '0;
      underflow   <= '0;
      cfg_err     <= 1'b0;
    end else begin
      if (start_ok) begin
        cells_sh <= i_CELLS_PER_FRAME;
        gap_sh   <= i_FRAME_GAP;
      end

      if (hdr_hs)     in_cnt <= cells_sh;
      else if (in_hs) in_cnt <= in_cnt - 32'd1;

      if (last_hs) begin
        frame_num <= frame_num + 32'd1;
        gap_cnt   <= gap_sh;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt - 16'd1;
      end

      if (i_CLR_STATS_wstrobe) frame_count <= '0;
      else if (last_hs)        frame_count <= frame_count + 32'd1;

      if (i_CLR_STATS_wstrobe)                       underflow <= '0;
      else if (uf_evt && (underflow != 32'hFFFFFFFF)) underflow <= underflow + 32'd1;

      if (i_CLR_STATS_wstrobe) cfg_err <= 1'b0;
      else if (start_bad)      cfg_err <= 1'b1;
      else if (start_ok)       cfg_err <= 1'b0;
    end
  end

  assign o_FRAME_COUNT = frame_count;
  assign o_UNDERFLOW   = underflow;
  assign o_CFG_ERR     = cfg_err;
  assign o_BUSY        = (state != ST_IDLE);

endmodule
